// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory, buffers up
// to two fetched words with their PCs, and hands them to decode over valid/ready.
module inst_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_inputReady,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_target,
    output logic [WORD_SIZE-1:0] num_fetch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DISCARD
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [WORD_SIZE-1:0] r_fetchPc;
    logic [WORD_SIZE-1:0] r_discardAddr;
    logic [WORD_SIZE-1:0] r_inst0;
    logic [WORD_SIZE-1:0] r_inst1;
    logic [WORD_SIZE-1:0] r_pc0;
    logic [WORD_SIZE-1:0] r_pc1;
    logic [1:0]           r_count;
    logic [WORD_SIZE-1:0] r_numFetch;

    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_countNext;

    assign w_pop  = (r_count != 2'd0) && inst_ready;
    assign w_push = (r_state == S_REQ) && i_inputReady && !redirect;

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // A request already issued to memory is never withdrawn: a redirect while it is
    // outstanding parks the FSM in S_DISCARD until its completion strobe arrives.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                w_nextState = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    w_nextState = i_inputReady ? S_REQ : S_DISCARD;
                end else if (w_push && (w_countNext == 2'd2)) begin
                    w_nextState = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect || (w_countNext < 2'd2)) begin
                    w_nextState = S_REQ;
                end
            end
            S_DISCARD: begin
                if (i_inputReady) begin
                    w_nextState = S_REQ;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetchPc     <= RESET_PC;
            r_discardAddr <= RESET_PC;
        end else begin
            if (redirect) begin
                r_fetchPc <= redirect_target;
            end else if (w_push) begin
                r_fetchPc <= r_fetchPc + 1'b1;
            end
            if ((r_state == S_REQ) && redirect && !i_inputReady) begin
                r_discardAddr <= r_fetchPc;
            end
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down so FIFO order survives
    // a simultaneous push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_inst0 <= '0;
            r_inst1 <= '0;
            r_pc0   <= '0;
            r_pc1   <= '0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_countNext;
            if (w_pop) begin
                if (w_push && (r_count == 2'd1)) begin
                    r_inst0 <= i_data;
                    r_pc0   <= r_fetchPc;
                end else begin
                    r_inst0 <= r_inst1;
                    r_pc0   <= r_pc1;
                    if (w_push) begin
                        r_inst1 <= i_data;
                        r_pc1   <= r_fetchPc;
                    end
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_inst0 <= i_data;
                    r_pc0   <= r_fetchPc;
                end else begin
                    r_inst1 <= i_data;
                    r_pc1   <= r_fetchPc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_numFetch <= '0;
        end else if (w_pop) begin
            r_numFetch <= r_numFetch + 1'b1;
        end
    end

    assign i_readM    = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign i_address  = (r_state == S_DISCARD) ? r_discardAddr : r_fetchPc;
    assign inst       = r_inst0;
    assign inst_pc    = r_pc0;
    assign inst_valid = (r_count != 2'd0);
    assign num_fetch  = r_numFetch;

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Front end of the 16-bit multi-cycle/pipelined CPU that produces the instruction word consumed by the control decoder. It issues word reads to instruction memory over the `readM`/`inputReady` handshake, buffers up to two fetched words with their PCs, and hands them to decode through a valid/ready handshake. It accepts PC redirects resolved from the decoder's jump and branch selects (`PCSrc1`, `PCSrc2`, branch taken), squashing stale fetches.

## Interface
- WORD_SIZE, 16, instruction, address and PC width.
- RESET_PC, 16'h0000, first fetch address after reset.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_readM  out  1  instruction-memory read request.
- i_address  out  WORD_SIZE  word address of the request.
- i_data  in  WORD_SIZE  read data, valid when i_inputReady=1.
- i_inputReady  in  1  one-cycle memory completion strobe.
- inst  out  WORD_SIZE  head-of-queue instruction to the decoder.
- inst_pc  out  WORD_SIZE  PC of `inst`.
- inst_valid  out  1  `inst`/`inst_pc` are valid.
- inst_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  flush the queue and refetch from `redirect_target`.
- redirect_target  in  WORD_SIZE  new fetch PC (jump, JPR/JRL register, or taken branch).
- num_fetch  out  WORD_SIZE  count of instructions handed to decode.

## Operation
- fetch_pc register: word-addressed, +1 per completed fetch, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Queue: 2 entries of {inst, pc}, FIFO order. Head drives `inst`/`inst_pc`. `inst_valid` = (count != 0). Pop when inst_valid && inst_ready.
- FSM states:
  - S_IDLE: reset state. readM=0. Goes to S_REQ on the next edge.
  - S_REQ: readM=1, address=fetch_pc. On i_inputReady: push {i_data, fetch_pc}; fetch_pc += 1. If count after push/pop is 2, go to S_FULL, else stay in S_REQ. The next address is presented the following cycle, and readM stays high.
  - S_FULL: readM=0. When a pop leaves count < 2, go to S_REQ.
  - S_DISCARD: readM=1, address held at the abandoned address. On i_inputReady: drop the data and go to S_REQ, which fetches the current fetch_pc.
- Redirect has the highest priority and is sampled at the clock edge:
  - Queue is cleared. A pop in the same cycle still counts as a consumed instruction.
  - fetch_pc <= redirect_target.
  - From S_REQ without i_inputReady in the same cycle: go to S_DISCARD. A request in flight is never withdrawn.
  - From S_REQ with i_inputReady in the same cycle: the returned word is dropped and the FSM stays in S_REQ.
  - From S_FULL or S_IDLE: go to S_REQ.
  - From S_DISCARD: stay in S_DISCARD with the new target.
- Push and pop in the same cycle with count=1: count stays 1 and order is preserved.
- num_fetch increments on every pop and wraps at 16 bits.

## Timing
- Reset (async assert) sets: state=S_IDLE, fetch_pc=RESET_PC, count=0, num_fetch=0. Outputs: i_readM=0, i_address=RESET_PC, inst=0, inst_pc=0, inst_valid=0.
- Release cycle numbering: cycle 1 is the first edge after reset_n rises (IDLE→REQ). readM=1 with address=RESET_PC from cycle 1 onward.
- Latency: inst_valid rises in the cycle after the edge that samples i_inputReady. Memory-to-decode latency is one cycle plus the memory latency.
- i_address and i_readM are functions of registered state only. They are stable for the whole request.
- Memory-side contract: at most one outstanding request; exactly one i_inputReady per request.
- Redirect-to-new-request latency:
  - 1 cycle if no request is in flight, or if i_inputReady coincides with the redirect.
  - Otherwise, the remaining memory latency plus 1.

## Test plan
- Reset then memory latency 2, inst_ready=1: the stream at PCs 0,1,2,3 returns words A0,A1,A2,A3 in order; num_fetch=4 after the fourth pop; readM never drops.
- inst_ready=0: after two completions the FSM enters S_FULL with readM=0 and head=PC 0. Raising inst_ready pops PC 0, and readM returns with address 2 one cycle later.
- Redirect to 16'h0040 while a request to PC 5 is pending (latency 3): that response is dropped and the next address is 16'h0040. The first valid inst_pc is 16'h0040, and nothing from PC 5 is ever presented.
- Redirect coinciding with i_inputReady, queue holding 1 entry being popped: the queue ends empty, num_fetch increments by 1, and the next address equals redirect_target in the next cycle.
- fetch_pc=16'hFFFF: the fetch completes, then the next address is 16'h0000 and inst_pc sequence FFFF, 0000 is observed.
- Assert reset_n low mid-request with two entries queued: inst_valid=0, readM=0 and num_fetch=0 immediately (asynchronously). After release, fetching restarts at RESET_PC.
